// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: two 32-bit requesters share one 64-bit async SRAM with fixed wait states.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise port A has fixed priority.
module sram_port_arbiter #(
    parameter int unsigned WAIT_CYCLES = 5,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_ready,
    output logic [31:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_ready,
    output logic [31:0] b_rdata,
    output logic        busy,
    output logic [16:0] SRAM_ADDR,
    inout  wire logic [63:0] SRAM_DQ,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic [1:0]  SRAM_BE_N
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          grant_b_q, grant_b_d;
    logic          we_q, we_d;
    logic [16:0]   addr_q, addr_d;
    logic          lane_q, lane_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          inr_q, inr_d;
    logic [31:0]   a_rdata_q, a_rdata_d;
    logic [31:0]   b_rdata_q, b_rdata_d;

    logic          grant_now;
    logic          pick_b;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_off;
    logic          sel_inr;
    logic [31:0]   rd_half;
    logic          pins_on;
    logic          unused_off;

    assign grant_now = (state_q == IDLE) && (a_req || b_req);

`ifdef SRAM_ARB_RR_EN
    logic last_b_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_b_q <= 1'b1;
        end else if (grant_now) begin
            last_b_q <= pick_b;
        end
    end

    assign pick_b = b_req && (!a_req || !last_b_q);
`else
    assign pick_b = b_req && !a_req;
`endif

    // Offset is taken modulo 2^32, so addresses below the base wrap and fail the range test too.
    assign sel_addr   = pick_b ? b_addr : a_addr;
    assign sel_off    = sel_addr - BASE_ADDR;
    assign sel_inr    = (sel_addr >= BASE_ADDR) && (sel_off[31:20] == '0);
    assign unused_off = ^sel_off[1:0];
    assign rd_half    = lane_q ? SRAM_DQ[63:32] : SRAM_DQ[31:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant_b_d = grant_b_q;
        we_d      = we_q;
        addr_d    = addr_q;
        lane_d    = lane_q;
        wdata_d   = wdata_q;
        inr_d     = inr_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_now) begin
                    grant_b_d = pick_b;
                    we_d      = pick_b ? b_we : a_we;
                    wdata_d   = pick_b ? b_wdata : a_wdata;
                    addr_d    = sel_off[19:3];
                    lane_d    = sel_off[2];
                    inr_d     = sel_inr;
                    cnt_d     = CW'(WAIT_CYCLES - 1);
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (grant_b_q) begin
                            b_rdata_d = inr_q ? rd_half : '0;
                        end else begin
                            a_rdata_d = inr_q ? rd_half : '0;
                        end
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            grant_b_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            lane_q    <= 1'b0;
            wdata_q   <= '0;
            inr_q     <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            grant_b_q <= grant_b_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            lane_q    <= lane_d;
            wdata_q   <= wdata_d;
            inr_q     <= inr_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    // Pins decode straight from state so an async reset releases the bus in the same cycle.
    assign pins_on   = (state_q == ACCESS) && inr_q;
    assign SRAM_CE_N = !pins_on;
    assign SRAM_WE_N = !(pins_on && we_q);
    assign SRAM_OE_N = !(pins_on && !we_q);
    assign SRAM_BE_N = pins_on ? (lane_q ? 2'b01 : 2'b10) : 2'b11;
    assign SRAM_ADDR = addr_q;
    assign SRAM_DQ   = (pins_on && we_q) ? {wdata_q, wdata_q} : 'z;

    assign a_ready = (state_q == DONE) && !grant_b_q;
    assign b_ready = (state_q == DONE) && grant_b_q;
    assign busy    = (state_q != IDLE);
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Multi-cycle controller that shares the single 64-bit off-chip SRAM between two 32-bit requesters. Port A is the MEM-stage data port; port B is the fetch/fill port.
Sequences each access with a fixed wait-state count and drives the raw SRAM pins. Returns a one-cycle ready pulse that the requester uses to release its pipeline freeze.

Parameters:
WAIT_CYCLES, 5, number of cycles SRAM pins are held active per access (min 1)
BASE_ADDR, 32'd1024, byte address mapped to SRAM offset 0

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
a_req  in  1  port A request, held until a_ready
a_we  in  1  port A write (1) / read (0)
a_addr  in  32  port A byte address
a_wdata  in  32  port A write data
a_ready  out  1  port A completion pulse
a_rdata  out  32  port A read data
b_req  in  1  port B request
b_we  in  1  port B write / read
b_addr  in  32  port B byte address
b_wdata  in  32  port B write data
b_ready  out  1  port B completion pulse
b_rdata  out  32  port B read data
busy  out  1  high in ACCESS and DONE
SRAM_ADDR  out  17  64-bit word address
SRAM_DQ  inout  64  SRAM data bus
SRAM_WE_N  out  1  write enable, active low
SRAM_OE_N  out  1  output enable, active low
SRAM_CE_N  out  1  chip enable, active low
SRAM_BE_N  out  2  32-bit lane enables, active low; [0]=DQ[31:0], [1]=DQ[63:32]

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; counter=0; a_rdata=b_rdata=0; a_ready=b_ready=0; busy=0.
  - SRAM_CE_N=SRAM_WE_N=SRAM_OE_N=1; SRAM_BE_N=2'b11; SRAM_ADDR=0; DQ=Z.
- Address map:
  - off = addr - BASE_ADDR; SRAM_ADDR = off[19:3]; lane = off[2]; addr[1:0] ignored.
  - Out of range (addr < BASE_ADDR or off >= 2^20): access proceeds with CE_N held 1, no pin activity, rdata written 0.
- States: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - Req/we/addr/wdata sampled only in IDLE.
  - If any req is high: grant per arbitration, latch grant, we, SRAM_ADDR, lane and wdata, set counter=WAIT_CYCLES-1, go ACCESS.
  - Pins are inactive in IDLE.
- ACCESS:
  - Pins driven from latched registers: CE_N=0 (if in range), WE_N=~we, OE_N=we, BE_N lane bit=0 and other=1.
  - On write, DQ={wdata,wdata}; on read, DQ=Z.
  - Counter decrements each cycle. When counter==0: on read, capture lane half of DQ into granted port's rdata; go DONE.
- DONE:
  - Pins inactive, DQ=Z.
  - Granted port's ready=1 for exactly this cycle; ungranted port's ready=0.
  - Return to IDLE.
- Latency: request seen in IDLE at cycle T -> ready at T+WAIT_CYCLES+1. Back-to-back accesses occupy WAIT_CYCLES+2 cycles each.
- Handshake:
  - Requester keeps req and its signals stable until ready.
  - A req still high in the IDLE cycle after DONE is a new access.
  - Changes to inputs during ACCESS are ignored.
- rdata: holds its value until the next read completion on that port. Writes leave rdata unchanged.
- Simultaneous a_req and b_req in IDLE: resolved by arbitration, one grant only. The loser waits in IDLE order; it is never dropped.
- Reset mid-ACCESS: pins deassert immediately (asynchronously). The write is aborted, no ready is issued, and the requester must re-request.
- DQ never driven except during a write ACCESS; no cycle drives DQ in both directions.

Optional Feature:
SRAM_ARB_RR_EN:
- Defined: round-robin. A last_grant register (reset to B) is updated at each grant. On simultaneous requests, grant the port not granted last.
- Undefined: fixed priority; port A always wins. Port B can starve under continuous A traffic.

Test Plan:
1. Reset: hold rst=0 with a_req=1 -> all pins 1, BE_N=2'b11, DQ=Z, a_ready=0, busy=0. Release -> access starts next edge.
2. WAIT_CYCLES=5; A write a_addr=0x408, a_wdata=0xDEADBEEF at cycle T:
   - SRAM_ADDR=1, BE_N=2'b10, WE_N=0 for 5 cycles.
   - DQ[31:0]=0xDEADBEEF.
   - a_ready pulses at T+6 only.
3. SRAM model word 1 = 0x11112222_33334444; B read b_addr=0x40C -> OE_N=0, BE_N=2'b01, b_rdata=0x11112222 at b_ready; a_rdata unchanged.
4. a_req and b_req both asserted at T:
   - Fixed priority: a_ready at T+6, b_ready at T+13.
   - With SRAM_ARB_RR_EN and last grant A: b_ready at T+6, a_ready at T+13.
5. a_addr=0x100 (below base), read -> CE_N stays 1, a_ready at T+6, a_rdata=0.
6. rst pulsed low at cycle T+3 of an A write -> WE_N=1 and DQ=Z within the same cycle, no a_ready. After release with a_req held, a full new access completes at release+6.
